// File: rtl/axi4_burst_splitter_if.sv
// Command + AXI4 address-channel bundle for axi4_burst_splitter.
//   master : the splitter side (takes commands, drives AR/AW requests)
//   slave  : the environment side (DMA descriptor logic + interconnect)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_beats : transfer command handshake
//   ax_valid/ax_ready/ax_addr/ax_len/ax_size/ax_burst : AXI4 INCR address request
interface axi4_burst_splitter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BEATS_WIDTH = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [BEATS_WIDTH-1:0] cmd_beats;

  logic                   ax_valid;
  logic                   ax_ready;
  logic [ADDR_WIDTH-1:0]  ax_addr;
  logic [7:0]             ax_len;
  logic [2:0]             ax_size;
  logic [1:0]             ax_burst;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats, ax_ready,
    output cmd_ready, ax_valid, ax_addr, ax_len, ax_size, ax_burst
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats, ax_ready,
    input  cmd_ready, ax_valid, ax_addr, ax_len, ax_size, ax_burst
  );
endinterface

// File: rtl/axi4_burst_splitter.sv
// Turns one DMA transfer command (start address + beat count) into a series of
// AXI4 INCR address requests. Each burst is clipped to MAX_BURST_LEN, to the
// next 4 KB boundary and to the beats still outstanding. Channel-agnostic: the
// request bundle can feed either AR or AW.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (abandons any command in flight)
//   bus  - master modport: command handshake in, address request out
//   busy - a command is in progress (state != IDLE)
//   done - one-cycle pulse after the last address of a command is accepted
//          (or the cycle after a zero-beat command is accepted)
module axi4_burst_splitter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BEATS_WIDTH   = 16,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_burst_splitter_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int CW    = (BEATS_WIDTH > 9) ? BEATS_WIDTH : 9;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q;     // start of the next burst
  logic [BEATS_WIDTH-1:0] rem_q;      // beats not yet covered by a request
  logic [8:0]             n_q;        // beats in the burst being issued
  logic [ADDR_WIDTH-1:0]  ax_addr_q;
  logic [7:0]             ax_len_q;
  logic                   done_q, done_nxt;

  logic                   accept, hs, last;
  logic [12:0]            to4k;       // beats left before the 4 KB page ends
  logic [8:0]             lim, n_calc;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign hs     = (state == ISSUE) && bus.ax_ready;
  assign last   = (CW'(rem_q) == CW'(n_q));

  // ---------------------------------------------------------------------------
  // Burst length: min(rem, MAX_BURST_LEN, to4k). MAX_BURST_LEN <= 256, so the
  // page/max limit always fits 9 bits; rem only wins when it is smaller still.
  // ---------------------------------------------------------------------------
  always_comb begin
    to4k   = (13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE;
    lim    = (to4k < 13'(MAX_BURST_LEN)) ? to4k[8:0] : 9'(MAX_BURST_LEN);
    n_calc = (CW'(rem_q) < CW'(lim)) ? 9'(rem_q) : lim;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_beats == '0) done_nxt  = 1'b1;
          else                     state_nxt = CALC;
        end
      end
      CALC: state_nxt = ISSUE;
      ISSUE: begin
        if (hs) begin
          if (last) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. ax_addr/ax_len only load in CALC, so they stay frozen for the
  // whole ISSUE phase regardless of how long ax_ready stays low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      n_q       <= '0;
      ax_addr_q <= '0;
      ax_len_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= bus.cmd_addr & ALIGN_MASK;
            rem_q  <= bus.cmd_beats;
          end
        end
        CALC: begin
          n_q       <= n_calc;
          ax_addr_q <= addr_q;
          ax_len_q  <= 8'(n_calc - 9'd1);
        end
        ISSUE: begin
          if (hs) begin
            addr_q <= addr_q + (ADDR_WIDTH'(n_q) << SIZE);
            rem_q  <= rem_q - BEATS_WIDTH'(n_q);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.ax_valid  = (state == ISSUE);
  assign bus.ax_addr   = ax_addr_q;
  assign bus.ax_len    = ax_len_q;
  assign bus.ax_size   = 3'(SIZE);
  assign bus.ax_burst  = 2'b01;  // INCR
  assign busy          = (state != IDLE);
  assign done          = done_q;

endmodule
